score_argmax_collector: RTL
===========================

SCORE_ARGMAX_COLLECTOR -- requirements
Module: score_argmax_collector

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 19, signed width of each incoming class score.
REQ-002 SHALL have parameter OUT_WIDTH, default 32, width of each stored score (OUT_WIDTH >= DATA_WIDTH).
REQ-003 SHALL have parameter CLASSES_QNT, default 10, scores per frame (>= 1).
REQ-004 SHALL have parameter IDX_WIDTH, default $clog2(CLASSES_QNT) min 1, width of the winning-index output.
REQ-005 SHALL use one clock and an asynchronous, active-low reset, with ports: clk  in  1  rising-edge clock; rst_n  in  1  async active-low reset.
REQ-006 SHALL have port: clk_en  in  1  global clock enable; all state frozen while low.
REQ-007 SHALL have ports: i_data  in  DATA_WIDTH  signed score; i_valid  in  1  beat valid; i_sop  in  1  first score of frame; i_eop  in  1  last score of frame.
REQ-008 SHALL have port: o_ready  out  1  upstream may present beats.
REQ-009 SHALL have ports: o_valid  out  1  result valid; i_ready  in  1  downstream accepts result.
REQ-010 SHALL have ports: o_classes  out  CLASSES_QNT x OUT_WIDTH  packed scores, index 0 = first beat; o_class_idx  out  IDX_WIDTH  argmax index; o_max_score  out  OUT_WIDTH  winning score; o_err  out  1  frame length error flag.

Function
REQ-011 SHALL accept a beat only when i_valid & o_ready & clk_en are all 1.
REQ-012 SHALL implement states IDLE, COLLECT, HOLD; o_ready = 1 in IDLE and COLLECT, 0 in HOLD.
REQ-013 IDLE: accepted beat with i_sop -> stores at index 0, counter = 1, running max/idx loaded with beat/0, goes COLLECT (or HOLD if i_eop on same beat); beats without i_sop are dropped.
REQ-014 COLLECT: each accepted beat is sign-extended to OUT_WIDTH and stored at the counter index; counter increments; entries not yet written in this frame read 0.
REQ-015 Argmax SHALL update only when new score > running max (signed, strict), so ties keep the lowest index.
REQ-016 Accepted beat with i_sop while in COLLECT SHALL abort the current frame and restart it from that beat (entries cleared, err cleared).
REQ-017 Accepted beats after CLASSES_QNT scores without i_eop SHALL be discarded (no store, no argmax update) and set the frame error bit.
REQ-018 Accepted i_eop beat SHALL go to HOLD; frame error bit also set if total stored count != CLASSES_QNT (short frame).
REQ-019 o_valid SHALL assert the cycle after the i_eop beat is accepted, with o_classes, o_class_idx, o_max_score, o_err stable until handoff.
REQ-020 In HOLD, i_ready & clk_en SHALL complete handoff: o_valid falls next cycle, state -> IDLE; result registers retain last values.
REQ-021 clk_en = 0 SHALL freeze state, counter, outputs and ignore i_ready/i_valid.
REQ-022 Counter SHALL saturate at CLASSES_QNT; no wrap-around.

Reset
REQ-023 rst_n low SHALL asynchronously force state IDLE, counter 0, o_valid 0, o_classes 0, o_class_idx 0, o_max_score 0, o_err 0; o_ready is 1 during and after reset.
REQ-024 Reset mid-frame or in HOLD SHALL discard the partial/pending result without emitting o_valid.

Verification
REQ-025 Full frame: 10 beats, scores -3,5,2,9,9,-1,0,4,1,7, sop on first, eop on last, i_ready=1 -> o_valid 1 cycle after eop, o_class_idx=3, o_max_score=9, o_classes[5]=32'hFFFFFFFF, o_err=0.
REQ-026 Backpressure: same frame, i_ready=0 for 5 cycles -> o_valid held, o_ready=0, data stable; i_ready=1 -> o_valid drops next cycle, o_ready=1.
REQ-027 Short frame: 6 beats, eop on 6th, all scores -2 -> o_err=1, o_class_idx=0, o_classes[6..9]=0.
REQ-028 Long frame: 12 beats, eop on 12th, beat 11 = +100 -> o_err=1, beat 11 ignored, argmax from first 10 beats only.
REQ-029 Restart/stall: sop mid-frame after 4 beats then 10-beat clean frame -> single o_valid, o_err=0, first 4 beats absent; clk_en=0 for 3 cycles mid-frame -> identical result to no stall.
REQ-030 Reset: assert rst_n=0 after beat 7 -> all outputs 0 immediately, no o_valid; following clean frame processed correctly.

Source files
------------

// File: rtl/score_argmax_collector_if.sv
// Score stream in, argmax result out. The slave modport is the collector's view;
// master is the view of whatever drives beats and consumes results.
interface score_argmax_collector_if #(
    parameter int DATA_WIDTH  = 19,
    parameter int OUT_WIDTH   = 32,
    parameter int CLASSES_QNT = 10,
    parameter int IDX_WIDTH   = (CLASSES_QNT > 1) ? $clog2(CLASSES_QNT) : 1
);
    // Handshake: a score beat transfers on a clock-enabled rising edge where
    // i_valid and o_ready are both high; a result transfers on a clock-enabled
    // edge where o_valid and i_ready are both high. Neither side may make valid
    // depend on the other side's ready.
    logic [DATA_WIDTH-1:0]             i_data;
    logic                              i_valid;
    logic                              i_sop;
    logic                              i_eop;
    logic                              o_ready;
    logic                              o_valid;
    logic                              i_ready;
    logic [CLASSES_QNT*OUT_WIDTH-1:0]  o_classes;
    logic [IDX_WIDTH-1:0]              o_class_idx;
    logic [OUT_WIDTH-1:0]              o_max_score;
    logic                              o_err;
    logic [1:0]                        dbg_state;

    modport slave (
        input  i_data, i_valid, i_sop, i_eop, i_ready,
        output o_ready, o_valid, o_classes, o_class_idx, o_max_score, o_err, dbg_state
    );

    modport master (
        output i_data, i_valid, i_sop, i_eop, i_ready,
        input  o_ready, o_valid, o_classes, o_class_idx, o_max_score, o_err, dbg_state
    );
endinterface

// File: rtl/score_argmax_collector.sv
// Collects one frame of signed class scores, tracks the running argmax and
// holds the packed scores, winner and length-error flag until handed off.
module score_argmax_collector #(
    parameter int DATA_WIDTH  = 19,
    parameter int OUT_WIDTH   = 32,
    parameter int CLASSES_QNT = 10,
    parameter int IDX_WIDTH   = (CLASSES_QNT > 1) ? $clog2(CLASSES_QNT) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clk_en,
    score_argmax_collector_if.slave     bus
);
    localparam int CNT_W = $clog2(CLASSES_QNT + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLASSES_QNT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_e;

    state_e                       state_q, state_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [OUT_WIDTH-1:0]         classes_q [CLASSES_QNT];
    logic [OUT_WIDTH-1:0]         classes_d [CLASSES_QNT];
    logic signed [OUT_WIDTH-1:0]  max_q, max_d;
    logic [IDX_WIDTH-1:0]         idx_q, idx_d;
    logic                         err_q, err_d;

    logic                         accept;
    logic                         start;
    logic signed [OUT_WIDTH-1:0]  beat_ext;

    assign beat_ext = OUT_WIDTH'($signed(bus.i_data));
    assign accept   = clk_en && bus.i_valid && (state_q != HOLD);
    // A sop beat restarts the frame from either IDLE or COLLECT.
    assign start    = accept && bus.i_sop;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        classes_d = classes_q;
        max_d     = max_q;
        idx_d     = idx_q;
        err_d     = err_q;

        unique case (state_q)
            IDLE, COLLECT: begin
                if (start) begin
                    for (int i = 0; i < CLASSES_QNT; i++) begin
                        classes_d[i] = '0;
                    end
                    classes_d[0] = beat_ext;
                    cnt_d        = CNT_W'(1);
                    max_d        = beat_ext;
                    idx_d        = '0;
                    err_d        = 1'b0;
                    if (bus.i_eop) begin
                        state_d = HOLD;
                        err_d   = (CNT_FULL != CNT_W'(1));
                    end else begin
                        state_d = COLLECT;
                    end
                end else if (accept && (state_q == COLLECT)) begin
                    if (cnt_q < CNT_FULL) begin
                        for (int i = 0; i < CLASSES_QNT; i++) begin
                            if (CNT_W'(i) == cnt_q) begin
                                classes_d[i] = beat_ext;
                            end
                        end
                        cnt_d = cnt_q + CNT_W'(1);
                        // Strict compare keeps the lowest index on ties.
                        if (beat_ext > max_q) begin
                            max_d = beat_ext;
                            idx_d = IDX_WIDTH'(cnt_q);
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                    if (bus.i_eop) begin
                        state_d = HOLD;
                        if (cnt_d != CNT_FULL) begin
                            err_d = 1'b1;
                        end
                    end
                end
            end
            HOLD: begin
                if (clk_en && bus.i_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            classes_q <= '{default: '0};
            max_q     <= '0;
            idx_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            classes_q <= classes_d;
            max_q     <= max_d;
            idx_q     <= idx_d;
            err_q     <= err_d;
        end
    end

    for (genvar g = 0; g < CLASSES_QNT; g++) begin : g_pack
        assign bus.o_classes[g*OUT_WIDTH +: OUT_WIDTH] = classes_q[g];
    end

    assign bus.o_ready     = (state_q != HOLD);
    assign bus.o_valid     = (state_q == HOLD);
    assign bus.o_class_idx = idx_q;
    assign bus.o_max_score = max_q;
    assign bus.o_err       = err_q;
    assign bus.dbg_state   = state_q;
endmodule
